// File: rtl/pd_file_mm_host.sv
// pd_file_mm_host: Avalon-MM host that moves linear blocks of words between
// the MATLAB bridge streams and a single-port 32-bit x 1024-word on-chip RAM.
// A command (start address + word count) is turned into one write per
// accepted input word, or a back-to-back read burst whose returning data is
// forwarded to the output stream after READ_LATENCY cycles.
//
// Optional build macro PD_FILE_MM_HOST_ABORT_EN adds an 'abort' input that
// cuts a running WRITE or READ short. Outstanding reads still drain and
// done still pulses.
module pd_file_mm_host #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [ADDR_W:0]       cmd_len,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_W-1:0]     wr_data,

    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,

    output logic                  done,
`ifdef PD_FILE_MM_HOST_ABORT_EN
    input  logic                  abort,
`endif

    output logic [ADDR_W-1:0]     av_address,
    output logic [DATA_W/8-1:0]   av_byteenable,
    output logic                  av_chipselect,
    output logic                  av_write,
    output logic [DATA_W-1:0]     av_writedata,
    input  logic [DATA_W-1:0]     av_readdata,
    output logic                  av_clken
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);

    state_t                  state;
    logic [ADDR_W-1:0]       ptr;
    logic [ADDR_W:0]         remaining;

    // One bit per read in flight; a 1 enters when a read is presented to the
    // slave and leaves at the far end exactly when its data is on av_readdata.
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [READ_LATENCY:0]   rd_pipe_ext;
    logic [READ_LATENCY-1:0] rd_pipe_next;
    logic                    read_presented;
    logic                    abort_req;

`ifdef PD_FILE_MM_HOST_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // The slave is never gated off and always writes full words.
    assign av_byteenable = '1;
    assign av_clken      = 1'b1;

    // A read is "presented" during the cycle the registered strobes show it.
    assign read_presented = av_chipselect & ~av_write;
    assign rd_pipe_ext    = {rd_pipe, read_presented};
    assign rd_pipe_next   = rd_pipe_ext[READ_LATENCY-1:0];

    // Read data passes straight through from the slave in its valid cycle;
    // forced to zero otherwise so the stream is quiet between words.
    assign rd_valid = rd_pipe[READ_LATENCY-1];
    assign rd_data  = rd_valid ? av_readdata : '0;

    // Command sequencer: state, address/count bookkeeping and every
    // registered strobe toward the slave and the bridge.
    // NOTE: all state here uses <= so every register samples the values from
    // before this edge; a blocking = would let later lines see updated values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            ptr           <= '0;
            remaining     <= '0;
            rd_pipe       <= '0;
            cmd_ready     <= 1'b0;
            wr_ready      <= 1'b0;
            done          <= 1'b0;
            av_chipselect <= 1'b0;
            av_write      <= 1'b0;
            av_address    <= '0;
            av_writedata  <= '0;
        end else begin
            // Defaults: strobes are single-cycle unless re-issued below.
            rd_pipe       <= rd_pipe_next;
            done          <= 1'b0;
            av_chipselect <= 1'b0;
            av_write      <= 1'b0;

            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        ptr       <= cmd_addr;
                        remaining <= cmd_len;
                        if (cmd_len == '0) begin
                            state <= S_DONE;
                        end else if (cmd_write) begin
                            state    <= S_WRITE;
                            wr_ready <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    // Each consumed word becomes one slave write next cycle;
                    // cycles without a word leave a bubble on the bus.
                    if (wr_valid && wr_ready) begin
                        av_chipselect <= 1'b1;
                        av_write      <= 1'b1;
                        av_address    <= ptr;
                        av_writedata  <= wr_data;
                        ptr           <= ptr + PTR_ONE;
                        remaining     <= remaining - LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            wr_ready <= 1'b0;
                            state    <= S_DONE;
                        end
                    end
                    if (abort_req) begin
                        wr_ready <= 1'b0;
                        state    <= S_DONE;
                    end
                end

                S_READ: begin
                    // One read per cycle; the address wraps with ptr width.
                    av_chipselect <= 1'b1;
                    av_write      <= 1'b0;
                    av_address    <= ptr;
                    ptr           <= ptr + PTR_ONE;
                    remaining     <= remaining - LEN_ONE;
                    if (remaining == LEN_ONE || abort_req) begin
                        state <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    // Leave once nothing is in flight after this edge, i.e.
                    // the last rd_valid has already been delivered.
                    if (rd_pipe_next == '0) begin
                        state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done      <= 1'b1;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pd_file_mm_host.sv
// Directed bench for pd_file_mm_host with a small behavioural RAM slave
// (read latency 1). Cycle index c=0 is the cycle right after the edge that
// accepts a command; outputs are sampled on the falling edge.
module tb_pd_file_mm_host;

    localparam int ADDR_W       = 10;
    localparam int DATA_W       = 32;
    localparam int READ_LATENCY = 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [9:0]        cmd_addr;
    logic [10:0]       cmd_len;
    logic              wr_valid;
    logic              wr_ready;
    logic [31:0]       wr_data;
    logic              rd_valid;
    logic [31:0]       rd_data;
    logic              done;
    logic              abort_drv;
    logic [9:0]        av_address;
    logic [3:0]        av_byteenable;
    logic              av_chipselect;
    logic              av_write;
    logic [31:0]       av_writedata;
    logic [31:0]       av_readdata;
    logic              av_clken;

    int checks = 0;
    int errors = 0;

    // Observations of one transfer, filled by run_xfer.
    logic [9:0]  obs_addr[$];
    logic        obs_wr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] rd_q[$];
    int          rd_cyc[$];
    int          done_cyc[$];
    logic        wr_ready_c0;

    always #5 clk = ~clk;

    pd_file_mm_host #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(READ_LATENCY)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
`ifdef PD_FILE_MM_HOST_ABORT_EN
        .abort(abort_drv),
`endif
        .av_address(av_address), .av_byteenable(av_byteenable),
        .av_chipselect(av_chipselect), .av_write(av_write),
        .av_writedata(av_writedata), .av_readdata(av_readdata),
        .av_clken(av_clken)
    );

    // RAM slave: preset to C000_0000|addr during reset, latency-1 reads.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hC000_0000 | i;
        end else if (av_chipselect && av_write) begin
            mem[av_address] <= av_writedata;
        end
        if (av_chipselect && !av_write) av_readdata <= mem[av_address];
    end

    task automatic send_cmd(input logic w, input logic [9:0] a,
                            input logic [10:0] l, output bit ok);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
            ok = 1'b0;
            return;
        end
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_xfer(input logic w, input logic [9:0] a, input logic [10:0] l,
                            input logic [31:0] dbase, input bit stall,
                            input int abort_c, input int ncyc, output bit ok);
        int idx = 0;
        obs_addr.delete(); obs_wr.delete(); obs_data.delete(); obs_cyc.delete();
        rd_q.delete(); rd_cyc.delete(); done_cyc.delete();
        send_cmd(w, a, l, ok);
        if (!ok) return;
        for (int c = 0; c < ncyc; c++) begin
            if (c == 0) wr_ready_c0 = wr_ready;
            if (av_chipselect) begin
                obs_addr.push_back(av_address);
                obs_wr.push_back(av_write);
                obs_data.push_back(av_writedata);
                obs_cyc.push_back(c);
            end
            if (rd_valid) begin
                rd_q.push_back(rd_data);
                rd_cyc.push_back(c);
            end
            if (done) done_cyc.push_back(c);
            if (w) begin
                wr_valid = (!stall || (c % 2 == 0)) && (idx < int'(l));
                wr_data  = dbase + 32'(idx);
                if (wr_valid && wr_ready) idx++;
            end
            abort_drv = (c == abort_c);
            @(negedge clk);
        end
        wr_valid  = 1'b0;
        abort_drv = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_len = '0; wr_valid = 1'b0; wr_data = '0; abort_drv = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, done, av_chipselect, av_write} !== 6'b0 ||
            av_address !== 10'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/wrr/rv/done/cs/wr=%b addr=%h required all 0",
                     {cmd_ready, wr_ready, rd_valid, done, av_chipselect, av_write}, av_address);
        end
        checks++;
        if (av_byteenable !== 4'hF || av_clken !== 1'b1) begin
            errors++;
            $display("FAIL constants: be=%h clken=%b required F 1", av_byteenable, av_clken);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_write_burst;
        bit ok;
        run_xfer(1'b1, 10'h010, 11'd4, 32'hA0, 1'b0, -1, 10, ok);
        if (!ok) return;
        checks++;
        if (wr_ready_c0 !== 1'b1) begin
            errors++;
            $display("FAIL wb_wr_ready: got %b required 1", wr_ready_c0);
        end
        checks++;
        if (obs_addr.size() != 4) begin
            errors++;
            $display("FAIL wb_count: got %0d strobes required 4", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            checks++;
            if (obs_wr[i] !== 1'b1 || obs_addr[i] !== 10'h010 + 10'(i) ||
                obs_data[i] !== 32'hA0 + 32'(i) || obs_cyc[i] != i + 1) begin
                errors++;
                $display("FAIL wb_beat%0d: wr=%b addr=%h data=%h cyc=%0d required 1 %h %h %0d",
                         i, obs_wr[i], obs_addr[i], obs_data[i], obs_cyc[i],
                         10'h010 + 10'(i), 32'hA0 + 32'(i), i + 1);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] <= 4 || done_cyc[0] > 6) begin
            errors++;
            $display("FAIL wb_done: pulses=%0d first=%0d required 1 pulse in cycle 5..6",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_readback;
        bit ok;
        run_xfer(1'b0, 10'h010, 11'd4, 32'h0, 1'b0, -1, 10, ok);
        if (!ok) return;
        checks++;
        if (rd_q.size() != 4 || rd_cyc[0] != READ_LATENCY + 1) begin
            errors++;
            $display("FAIL rb_count: got %0d words first cyc %0d required 4 at %0d",
                     rd_q.size(), rd_cyc.size() > 0 ? rd_cyc[0] : -1, READ_LATENCY + 1);
        end
        for (int i = 0; i < rd_q.size() && i < 4; i++) begin
            checks++;
            if (rd_q[i] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL rb_data%0d: got %h required %h", i, rd_q[i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_stalled_write;
        bit ok;
        run_xfer(1'b1, 10'h020, 11'd3, 32'hB0, 1'b1, -1, 12, ok);
        if (!ok) return;
        checks++;
        if (obs_addr.size() != 3) begin
            errors++;
            $display("FAIL sw_count: got %0d strobes required 3", obs_addr.size());
        end
        for (int i = 0; i < obs_addr.size() && i < 3; i++) begin
            checks++;
            if (obs_wr[i] !== 1'b1 || obs_addr[i] !== 10'h020 + 10'(i) ||
                obs_data[i] !== 32'hB0 + 32'(i) || obs_cyc[i] != 2 * i + 1) begin
                errors++;
                $display("FAIL sw_beat%0d: wr=%b addr=%h data=%h cyc=%0d required 1 %h %h %0d",
                         i, obs_wr[i], obs_addr[i], obs_data[i], obs_cyc[i],
                         10'h020 + 10'(i), 32'hB0 + 32'(i), 2 * i + 1);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] <= 5 || done_cyc[0] > 7) begin
            errors++;
            $display("FAIL sw_done: pulses=%0d first=%0d required 1 pulse in cycle 6..7",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_read_wrap;
        bit ok;
        logic [9:0] ea;
        run_xfer(1'b0, 10'h3FE, 11'd4, 32'h0, 1'b0, -1, 12, ok);
        if (!ok) return;
        checks++;
        if (obs_addr.size() != 4 || wr_ready_c0 !== 1'b0) begin
            errors++;
            $display("FAIL rw_issue_count: got %0d issues wr_ready=%b required 4 and 0",
                     obs_addr.size(), wr_ready_c0);
        end
        for (int i = 0; i < obs_addr.size() && i < 4; i++) begin
            ea = 10'h3FE + 10'(i);
            checks++;
            if (obs_wr[i] !== 1'b0 || obs_addr[i] !== ea || obs_cyc[i] != i + 1) begin
                errors++;
                $display("FAIL rw_issue%0d: wr=%b addr=%h cyc=%0d required 0 %h %0d",
                         i, obs_wr[i], obs_addr[i], obs_cyc[i], ea, i + 1);
            end
        end
        checks++;
        if (rd_q.size() != 4) begin
            errors++;
            $display("FAIL rw_rd_count: got %0d words required 4", rd_q.size());
        end
        for (int i = 0; i < rd_q.size() && i < 4; i++) begin
            ea = 10'h3FE + 10'(i);
            checks++;
            if (rd_q[i] !== (32'hC000_0000 | 32'(ea)) || rd_cyc[i] != i + 2) begin
                errors++;
                $display("FAIL rw_data%0d: data=%h cyc=%0d required %h %0d",
                         i, rd_q[i], rd_cyc[i], 32'hC000_0000 | 32'(ea), i + 2);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] <= 5 || done_cyc[0] > 8) begin
            errors++;
            $display("FAIL rw_done: pulses=%0d first=%0d required 1 pulse in cycle 6..8",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
    endtask

    task automatic test_null;
        bit ok;
        run_xfer(1'b0, 10'h055, 11'd0, 32'h0, 1'b0, -1, 5, ok);
        if (!ok) return;
        checks++;
        if (obs_addr.size() != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL null_bus: got %0d selects %0d words required 0 0",
                     obs_addr.size(), rd_q.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] < 1 || done_cyc[0] > 2) begin
            errors++;
            $display("FAIL null_done: pulses=%0d first=%0d required 1 pulse in cycle 1..2",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL null_ready: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        int activity = 0;
        send_cmd(1'b0, 10'h000, 11'd16, ok);
        if (!ok) return;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (av_chipselect !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_active: av_chipselect=%b required 1", av_chipselect);
        end
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cmd_ready, wr_ready, rd_valid, done, av_chipselect, av_write} !== 6'b0 ||
                av_address !== 10'h0 || rd_data !== 32'h0) begin
                errors++;
                $display("FAIL rst_hold%0d: rdy/wrr/rv/done/cs/wr=%b addr=%h rd_data=%h required 0",
                         i, {cmd_ready, wr_ready, rd_valid, done, av_chipselect, av_write},
                         av_address, rd_data);
            end
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready: cmd_ready=%b required 1", cmd_ready);
        end
        for (int i = 0; i < 20; i++) begin
            if (done || rd_valid || av_chipselect) activity++;
            @(negedge clk);
        end
        checks++;
        if (activity != 0) begin
            errors++;
            $display("FAIL rst_abandon: %0d active cycles after reset required 0", activity);
        end
    endtask

`ifdef PD_FILE_MM_HOST_ABORT_EN
    task automatic test_abort;
        bit ok;
        run_xfer(1'b0, 10'h100, 11'd16, 32'h0, 1'b0, 4, 16, ok);
        if (!ok) return;
        checks++;
        if (obs_addr.size() != 5 || rd_q.size() != 5) begin
            errors++;
            $display("FAIL ab_count: got %0d issues %0d words required 5 5",
                     obs_addr.size(), rd_q.size());
        end
        for (int i = 0; i < rd_q.size() && i < 5; i++) begin
            checks++;
            if (rd_q[i] !== (32'hC000_0100 + 32'(i))) begin
                errors++;
                $display("FAIL ab_data%0d: got %h required %h", i, rd_q[i], 32'hC000_0100 + 32'(i));
            end
        end
        checks++;
        if (done_cyc.size() != 1 || rd_cyc.size() == 0 ||
            done_cyc[0] <= rd_cyc[rd_cyc.size() - 1]) begin
            errors++;
            $display("FAIL ab_done: pulses=%0d first=%0d required 1 pulse after last rd_valid",
                     done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_burst();
        test_readback();
        test_stalled_write();
        test_read_wrap();
        test_null();
        test_reset_mid_read();
`ifdef PD_FILE_MM_HOST_ABORT_EN
        test_abort();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pd_file_mm_host.md
Name: pd_file_mm_host

Overview:
- Avalon-MM host (initiator) that drives the single-port 32-bit x 1024-word on-chip RAM slave.
- Accepts linear block-transfer commands from the MATLAB bridge logic: start address plus word count.
- Sequences per-word writes from an input data stream, or reads to an output data stream.
- Pipelines reads against the RAM's fixed read latency, auto-increments the address and signals completion.

Parameters:
- ADDR_W, 10, word-address width of the RAM slave.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, cycles from address/chipselect (read) to valid av_readdata; legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block idle, command accepted on cmd_valid & cmd_ready.
- cmd_write  in  1  1 = write transfer, 0 = read transfer.
- cmd_addr  in  ADDR_W  start word address.
- cmd_len  in  ADDR_W+1  word count, 1..1024; 0 = null command.
- wr_valid  in  1  write data word offered.
- wr_ready  out  1  write word consumed on wr_valid & wr_ready.
- wr_data  in  DATA_W  write data.
- rd_valid  out  1  read data word valid (no backpressure; sink must accept).
- rd_data  out  DATA_W  read data.
- done  out  1  one-cycle pulse when a command fully completes.
- av_address  out  ADDR_W  slave address.
- av_byteenable  out  DATA_W/8  always all ones.
- av_chipselect  out  1  slave select.
- av_write  out  1  write strobe.
- av_writedata  out  DATA_W  write data to slave.
- av_readdata  in  DATA_W  read data from slave.
- av_clken  out  1  slave clock enable; constant 1.

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE, all av_* strobes 0, av_address 0, rd_valid 0, done 0, wr_ready 0, cmd_ready 0 during reset. Internal counters and the latency shift register are cleared. Reset mid-transfer abandons the command; no done pulse.
- State IDLE: cmd_ready=1. On accept:
  - latch address into ptr and cmd_len into remaining.
  - cmd_len=0 → DONE.
  - cmd_write=1 → WRITE.
  - cmd_write=0 → READ.
- State WRITE:
  - wr_ready=1. Each cycle with wr_valid: registered av_chipselect=1, av_write=1, av_address=ptr, av_writedata=wr_data.
  - Then ptr+1 (wraps 1023→0) and remaining-1.
  - Cycles without wr_valid: chipselect/write 0 (bubble).
  - When the last word is accepted → DONE; the slave write is still presented on the next cycle.
- State READ:
  - Each cycle issues av_chipselect=1, av_write=0, av_address=ptr, then ptr+1 (wrap) and remaining-1. Back-to-back, one word per cycle.
  - Each issue shifts a 1 into a READ_LATENCY-deep valid shift register; non-issue cycles shift in 0.
  - rd_valid = shift-register output; rd_data = av_readdata, sampled combinationally in that cycle.
  - After the last issue → DRAIN.
- State DRAIN: no issues. Wait until the shift register is all zero, i.e. the last rd_valid has fired → DONE.
- State DONE: done=1 for exactly one cycle, cmd_ready=0 → IDLE.
- First read data appears READ_LATENCY+1 cycles after the cmd accept edge. Data order equals address order.
- Wrap: start 1020, len 8 → addresses 1020..1023, 0..3.
- av_write and a read issue are never asserted in the same cycle.
- cmd_valid is ignored outside IDLE. wr_ready=0 outside WRITE.

Optional Feature:
- Macro PD_FILE_MM_HOST_ABORT_EN adds input abort (1 bit).
- With the macro: abort=1 in WRITE or READ stops further issues the next cycle.
  - READ goes to DRAIN; outstanding reads still deliver rd_valid.
  - WRITE goes to DONE.
  - done pulses normally; abort is ignored in IDLE, DRAIN and DONE.
- Without the macro: no abort port; commands always run to completion.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles during an active READ → all outputs 0, cmd_ready=1 the cycle after release, no done.
- Write burst: cmd addr=0x010 len=4 write, wr_data 0xA0..0xA3 every cycle → av_write at addresses 0x010..0x013 on 4 consecutive cycles, one done pulse; read-back returns 0xA0..0xA3.
- Stalled write: len=3 with wr_valid low on alternate cycles → exactly 3 av_write strobes, addresses consecutive, done after the third.
- Read pipelining, READ_LATENCY=1: addr=0x3FE len=4 → av_address 0x3FE,0x3FF,0x000,0x001 back-to-back; rd_valid 4 consecutive cycles, first 2 cycles after accept; done after the last.
- Null command: cmd_len=0 → no av_chipselect, done 2 cycles after accept, cmd_ready back high.
- With PD_FILE_MM_HOST_ABORT_EN: read len=16, abort at the 5th issue → exactly 5 rd_valid, then done.
